data_mem_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the single-port 1024x32 data memory (BRAM).
- Shares the memory between requester 0 (processor load/store unit) and requester 1 (program/data loader or debug port).
- Serialises each request into exactly one enable/write-enable pulse on the memory.
- Waits the memory read latency, then returns an ack, plus read data for loads, to the winning requester.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/data_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default widths
// and requester identifiers.
package dmem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone request wins outright, a
// contest goes to whichever requester was not granted last.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = REQ_LDR;
        end else begin
            grant_id = REQ_CPU;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sequencer sharing one single-port data memory between the CPU
// load/store unit and the loader/debug port; one memory pulse per request.
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] WAIT_LOAD = 3'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              busy_q, busy_d;
    logic              arb_valid, arb_id;
    logic              enter_done;

    rr_arbiter2 u_arb (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant_q),
        .grant_valid (arb_valid),
        .grant_id    (arb_id)
    );

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        enter_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d     = ISSUE;
                    grant_id_d  = arb_id;
                    we_d        = arb_id ? m1_we : m0_we;
                    mem_addr_d  = arb_id ? m1_addr : m0_addr;
                    mem_wdata_d = arb_id ? m1_wdata : m0_wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = arb_id ? m1_we : m0_we;
                end
            end
            ISSUE: begin
                last_grant_d = grant_id_q;
                if (READ_LAT > 1) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acks are registered so they line up exactly with the DONE cycle.
        m0_ack_d = enter_done && (grant_id_q == REQ_CPU);
        m1_ack_d = enter_done && (grant_id_q == REQ_LDR);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= REQ_CPU;
            last_grant_q <= REQ_LDR;
            we_q         <= 1'b0;
            cnt_q        <= 3'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            busy_q       <= busy_d;
        end
    end

    // Read data comes straight from the memory during the ack cycle.
    assign m0_rdata  = (m0_ack_q && !we_q) ? mem_rdata : '0;
    assign m1_rdata  = (m1_ack_q && !we_q) ? mem_rdata : '0;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: one instance with READ_LAT=1 (index 0)
// and one with READ_LAT=3 (index 1), each in front of a behavioural BRAM.
module tb_data_mem_arbiter;

    typedef struct {
        int          dut;
        int          id;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2][2];
    logic        we    [2][2];
    logic [9:0]  addr  [2][2];
    logic [31:0] wdata [2][2];
    logic        ack   [2][2];
    logic [31:0] rdata [2][2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [9:0]  mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic        busy [2];
    logic [31:0] rdata_a, rdata_b, b_s0, b_s1;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] shadow [2][1024];

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(rdata_a), .busy(busy[0])
    );

    data_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(rdata_b), .busy(busy[1])
    );

    // Latency-1 BRAM, and a latency-3 BRAM built from two extra output stages.
    always @(posedge clk) begin
        if (mem_en[0]) begin
            if (mem_we[0]) mem_a[mem_addr[0]] = mem_wdata[0];
            else rdata_a <= mem_a[mem_addr[0]];
        end
        if (mem_en[1]) begin
            if (mem_we[1]) mem_b[mem_addr[1]] = mem_wdata[1];
            else b_s0 <= mem_b[mem_addr[1]];
        end
        b_s1    <= b_s0;
        rdata_b <= b_s1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input int d, input int id, input logic [31:0] rd, input int ecyc);
        exp_t e;
        e.dut = d; e.id = id; e.rdata = rd; e.cyc = ecyc;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int d, input int p, input logic w, input logic [9:0] a,
                                 input logic [31:0] dat, input int ecyc);
        pushExp(d, p, w ? 32'h0 : shadow[d][a], ecyc);
        if (w) shadow[d][a] = dat;
        we[d][p]    = w;
        addr[d][p]  = a;
        wdata[d][p] = dat;
        req[d][p]   = 1'b1;
    endtask

    task automatic waitAck(input int d, input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[d][p] && n < 30);
        if (!ack[d][p]) checkOutput("ack_timeout", 64'd0, 64'd1);
        req[d][p] = 1'b0;
    endtask

    task automatic checkReset(input int d);
        checkOutput("rst_mem_en", 64'(mem_en[d]), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we[d]), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr[d]), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata[d]), 64'd0);
        checkOutput("rst_m0_ack", 64'(ack[d][0]), 64'd0);
        checkOutput("rst_m1_ack", 64'(ack[d][1]), 64'd0);
        checkOutput("rst_m0_rdata", 64'(rdata[d][0]), 64'd0);
        checkOutput("rst_m1_rdata", 64'(rdata[d][1]), 64'd0);
        checkOutput("rst_busy", 64'(busy[d]), 64'd0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Every ack pops the oldest expectation and is checked for instance, port, cycle and data.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d][0] && ack[d][1]) checkOutput("dual_ack", 64'd1, 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (ack[d][p]) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_ack", 64'(p), 64'hFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        checkOutput("ack_dut", 64'(d), 64'(e.dut));
                        checkOutput("ack_id", 64'(p), 64'(e.id));
                        checkOutput("ack_cycle", 64'(cyc), 64'(e.cyc));
                        checkOutput("ack_rdata", 64'(rdata[d][p]), 64'(e.rdata));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int en_cnt;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
            end
        end
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'hA5A5_0000 | i;
            mem_b[i] = 32'h5A5A_0000 | i;
            shadow[0][i] = 32'hA5A5_0000 | i;
            shadow[1][i] = 32'h5A5A_0000 | i;
        end
        mem_b[10'h200] = 32'hCAFEF00D;
        shadow[1][10'h200] = 32'hCAFEF00D;

        repeat (2) @(negedge clk);
        checkReset(0);
        checkReset(1);
        rst = 1'b0;

        // Single write then read-back on the latency-1 instance.
        @(negedge clk);
        c = cyc;
        applyStimulus(0, 0, 1'b1, 10'h005, 32'hDEADBEEF, c + 2);
        @(negedge clk);
        checkOutput("wr_mem_en", 64'(mem_en[0]), 64'd1);
        checkOutput("wr_mem_we", 64'(mem_we[0]), 64'd1);
        checkOutput("wr_mem_addr", 64'(mem_addr[0]), 64'h005);
        checkOutput("wr_mem_wdata", 64'(mem_wdata[0]), 64'hDEADBEEF);
        waitAck(0, 0);
        checkOutput("wr_done_en", 64'(mem_en[0]), 64'd0);
        @(negedge clk);
        c = cyc;
        applyStimulus(0, 0, 1'b0, 10'h005, 32'h0, c + 2);
        waitAck(0, 0);

        // Simultaneous requests straight after reset: CPU first.
        pulseReset();
        @(negedge clk);
        c = cyc;
        applyStimulus(0, 0, 1'b0, 10'h001, 32'h0, c + 2);
        applyStimulus(0, 1, 1'b1, 10'h3FF, 32'h1234_5678, c + 5);
        waitAck(0, 0);
        @(negedge clk);
        checkOutput("sim_idle_busy", 64'(busy[0]), 64'd0);
        @(negedge clk);
        checkOutput("sim_m1_en", 64'(mem_en[0]), 64'd1);
        checkOutput("sim_m1_we", 64'(mem_we[0]), 64'd1);
        checkOutput("sim_m1_addr", 64'(mem_addr[0]), 64'h3FF);
        waitAck(0, 1);

        // Continuous contention for 8 transactions: strict alternation.
        @(negedge clk);
        c = cyc;
        we[0][0] = 1'b0; addr[0][0] = 10'h005;
        we[0][1] = 1'b0; addr[0][1] = 10'h3FF;
        for (int k = 0; k < 8; k++)
            pushExp(0, k % 2, (k % 2) ? shadow[0][10'h3FF] : shadow[0][10'h005], c + 2 + 3 * k);
        req[0][0] = 1'b1;
        req[0][1] = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            checkOutput("cont_busy", 64'(busy[0]), (i % 3 == 0) ? 64'd0 : 64'd1);
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        @(negedge clk);
        checkOutput("cont_end_busy", 64'(busy[0]), 64'd0);

        // Latency-3 read by the loader port.
        @(negedge clk);
        c = cyc;
        en_cnt = 0;
        applyStimulus(1, 1, 1'b0, 10'h200, 32'h0, c + 4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (mem_en[1]) en_cnt++;
        end
        req[1][1] = 1'b0;
        checkOutput("lat3_en_pulses", 64'(en_cnt), 64'd1);

        // Address change after the grant must not reach the memory.
        @(negedge clk);
        c = cyc;
        applyStimulus(1, 0, 1'b0, 10'h010, 32'h0, c + 4);
        @(negedge clk);
        addr[1][0] = 10'h020;
        checkOutput("late_addr", 64'(mem_addr[1]), 64'h010);
        waitAck(1, 0);

        // Reset in the middle of a latency-3 read aborts it without an ack.
        @(negedge clk);
        we[1][0] = 1'b0; addr[1][0] = 10'h005; req[1][0] = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_busy", 64'(busy[1]), 64'd1);
        rst = 1'b1;
        #1;
        checkReset(1);
        req[1][0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c = cyc;
        applyStimulus(1, 1, 1'b0, 10'h3FF, 32'h0, c + 4);
        waitAck(1, 1);
        @(negedge clk);
        c = cyc;
        applyStimulus(1, 0, 1'b0, 10'h010, 32'h0, c + 4);
        applyStimulus(1, 1, 1'b0, 10'h200, 32'h0, c + 9);
        waitAck(1, 0);
        waitAck(1, 1);

        repeat (4) @(negedge clk);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
